fetch_controller: RTL

Sequences the program counter and instruction-fetch stage of the 5-stage RISC-V pipeline. It drives the PC's increment and jump controls from the instruction-memory handshake, ID-stage load-use stalls, and EX-stage branch/jump redirects. It also produces the IF/ID write-enable and valid bit, and flags a hung instruction memory.

---
 rtl/fetch_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// fetch_controller
// Drives the PC increment/jump controls and the IF/ID write-enable/valid bit
// from the instruction-memory handshake, load-use stalls and EX redirects.
// Also raises a sticky flag when instruction memory stops answering.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_BOOT     | post-reset idle, no fetch, IF/ID filled with bubbles
// S_FETCH    | normal fetch, one instruction per ready cycle
// S_REDIRECT | redirect seen while a fetch was in flight; wait for it to land
module fetch_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BOOT_DELAY     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  input  logic                  imem_ready_i,
  output logic                  imem_req_o,
  output logic                  pc_en_o,
  output logic                  pc_jump_en_o,
  output logic [ADDR_WIDTH-1:0] pc_target_o,
  output logic                  if_id_we_o,
  output logic                  if_id_valid_o,
  output logic                  imem_timeout_o
);

  localparam int BOOT_W = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  logic [1:0]            r_state;
  logic [BOOT_W-1:0]     r_boot_cnt;
  logic [ADDR_WIDTH-1:0] r_pending;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_timeout;

  logic [1:0]            w_state_nxt;
  logic [BOOT_W-1:0]     w_boot_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_pending_nxt;
  logic [TO_W-1:0]       w_to_cnt_nxt;
  logic                  w_req;
  logic                  w_pc_en;
  logic                  w_jump;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_we;
  logic                  w_valid;
  logic                  w_to_hit;

  // FSM next-state and all handshake outputs; BOOT values double as the
  // reset values since the state register clears asynchronously.
  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    w_pending_nxt  = r_pending;
    w_req          = 1'b0;
    w_pc_en        = 1'b0;
    w_jump         = 1'b0;
    w_target       = '0;
    w_we           = 1'b1;
    w_valid        = 1'b0;

    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt    = S_FETCH;
          w_boot_cnt_nxt = '0;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + 1'b1;
        end
      end

      S_FETCH: begin
        // A redirect overrides a stall: the wrong-path request must stay up
        // so the in-flight access can complete and be discarded.
        w_req    = ~(stall_i & ~redirect_i);
        w_target = redirect_addr_i;
        if (redirect_i && imem_ready_i) begin
          w_jump = 1'b1;
        end else if (redirect_i) begin
          w_pending_nxt = redirect_addr_i;
          w_state_nxt   = S_REDIRECT;
        end else if (stall_i) begin
          w_we = 1'b0;
        end else if (imem_ready_i) begin
          w_pc_en = 1'b1;
          w_valid = 1'b1;
        end
      end

      S_REDIRECT: begin
        // Newest redirect wins, including one arriving on the landing cycle.
        w_req    = 1'b1;
        w_target = redirect_i ? redirect_addr_i : r_pending;
        if (redirect_i) begin
          w_pending_nxt = redirect_addr_i;
        end
        if (imem_ready_i) begin
          w_jump      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // Timeout counter: counts consecutive unanswered request cycles, saturating.
  always_comb begin
    w_to_cnt_nxt = '0;
    if (w_req && !imem_ready_i) begin
      w_to_cnt_nxt = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
    end
    w_to_hit = (w_to_cnt_nxt == TO_MAX);
  end

  // State, counters, pending target and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
      r_pending  <= '0;
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_timeout  <= r_timeout | w_to_hit;
    end
  end

  assign imem_req_o     = w_req;
  assign pc_en_o        = w_pc_en;
  assign pc_jump_en_o   = w_jump;
  assign pc_target_o    = w_target;
  assign if_id_we_o     = w_we;
  assign if_id_valid_o  = w_valid;
  assign imem_timeout_o = r_timeout;

endmodule
